decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised, registered binary-to-one-hot decoder. Successor to the fixed 3-to-8 combinational decoder. Generalises select width to N bits, registers the output, and adds two sequenced modes for display-digit and row-select drivers:
- continuous auto-scan with a programmable dwell per slot;
- one-shot sweep with a completion pulse.

## Interface
Parameters:
- N, 3, select width; output width is 2**N (N >= 1)
- DWELL, 4, clock cycles each slot is held in SCAN/SWEEP (DWELL >= 1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  clock enable; low freezes every register, including y, cur, counter, state and done
- mode  input  2  00 DIRECT, 01 SCAN, 10 SWEEP, 11 OFF
- start  input  1  single-cycle pulse; launches SCAN or SWEEP from slot a
- a  input  N  binary select (DIRECT) / start slot (SCAN, SWEEP)
- y  output  2**N  registered one-hot output; all-zero when idle
- cur  output  N  currently selected slot
- busy  output  1  high while in SCAN or SWEEP
- done  output  1  one-cycle pulse at normal SWEEP completion

## Operation
- States: IDLE, DIRECT, SCAN, SWEEP. All evaluation happens at clk edges with en=1.
- Internal dwell counter: width max(1, clog2(DWELL)), range 0..DWELL-1.
- Output invariant: y == (1 << cur) in DIRECT, SCAN and SWEEP; y == 0 in IDLE.
- IDLE:
  - mode=DIRECT -> DIRECT, cur<=a.
  - mode=SCAN and start -> SCAN.
  - mode=SWEEP and start -> SWEEP.
  - Entering SCAN or SWEEP sets cur<=a and counter<=0.
  - mode=OFF, or SCAN/SWEEP without start -> stay in IDLE.
- DIRECT:
  - cur<=a on every enabled edge.
  - mode != DIRECT -> IDLE.
- SCAN:
  - counter increments each enabled edge.
  - When counter==DWELL-1: cur<=cur+1 modulo 2**N (2**N-1 wraps to 0), counter<=0.
  - Runs until mode changes.
- SWEEP:
  - Advances the same way as SCAN.
  - When cur==2**N-1 and counter==DWELL-1: go to IDLE, y<=0, done<=1.
- Precedence, highest first:
  1. Mode change. Active state becomes IDLE at that edge with y<=0 and no done pulse, even if start is high. Exception: DIRECT is entered directly when mode=DIRECT.
  2. start while already in SCAN or SWEEP with the same mode. Restarts at cur<=a with counter<=0 and no done pulse, even if the sweep would have completed on that edge.
  3. Normal advance.
- start is ignored in DIRECT and OFF.
- Reset mid-operation: asynchronous return to IDLE. Any in-flight sweep is discarded and no done is produced.

## Timing
- Reset values: y=0, cur=0, busy=0, done=0, counter=0, state=IDLE.
- DIRECT latency: a sampled at edge k appears on y after edge k (one cycle).
- SCAN/SWEEP latency: start at edge k gives y=1<<a after edge k.
  - Each slot is held exactly DWELL enabled cycles.
  - Slot advances at edges k+DWELL, k+2·DWELL, ...
  - en=0 cycles do not count.
- SWEEP from slot s lasts (2**N - s)·DWELL enabled cycles.
  - done is high for exactly the single cycle after the final slot expires, coincident with y=0 and busy=0.
  - done clears at the next enabled edge.
  - If en is low, done holds until the next enabled edge.
- DWELL=1: slot advances every enabled edge.
- busy is registered and follows state: high in SCAN/SWEEP, low in IDLE, DIRECT and OFF.

## Test plan
- Reset/DIRECT, N=3: assert rst_n=0 mid-run -> y=0, cur=0, done=0 immediately. Then mode=00 with a=0..7 -> y=01,02,04,...,80, each one cycle after a is applied.
- SCAN wrap, N=3, DWELL=2: start with a=6 -> y = 40,40,80,80,01,01,02,... and busy=1 throughout. Set mode=11 -> y=0 and busy=0 next cycle.
- SWEEP, N=3, DWELL=3: start with a=5 -> y=20×3, 40×3, 80×3, then y=0 with done=1 for one cycle. Total is 9 busy cycles.
- en gating, SCAN, N=2, DWELL=2: drop en for 5 cycles mid-slot -> y, cur and counter frozen; the slot resumes with its remaining dwell cycles.
- Restart/abort, SWEEP, N=3, DWELL=2:
  - start a=2, then start a=6 at the 3rd cycle -> output restarts at 40 and no done until 80 expires.
  - Switch mode to 00 during the sweep -> DIRECT decode of a, no done pulse.
- Parameter sweep: N=1 with DWELL=1 and N=5 with DWELL=7. Full SWEEP from a=0 -> all 2**N one-hot values in order, done after 2**N·DWELL cycles.

Source files
------------

// File: rtl/decoder_scan_if.sv
// Handshake bundle for decoder_scan.
// Master drives the controls; slave returns the decode.
interface decoder_scan_if #(
    parameter int N = 3
) ();
    logic             en;
    logic [1:0]       mode;
    logic             start;
    logic [N-1:0]     a;
    logic [2**N-1:0]  y;
    logic [N-1:0]     cur;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, start, a,
        input  y, cur, busy, done
    );

    modport slave (
        input  en, mode, start, a,
        output y, cur, busy, done
    );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2**N one-hot decoder with direct,
// auto-scan and one-shot sweep modes.
module decoder_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_scan_if.slave  bus
);
    localparam int M  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  CMAX = {N{1'b1}};

    localparam logic [1:0] MD_DIRECT = 2'b00;
    localparam logic [1:0] MD_SCAN   = 2'b01;
    localparam logic [1:0] MD_SWEEP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE, S_DIRECT, S_SCAN, S_SWEEP
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_cur;
    logic [CW-1:0]   r_cnt;
    logic [M-1:0]    r_y;
    logic            r_busy;
    logic            r_done;

    state_t          w_state;
    logic [N-1:0]    w_cur;
    logic [CW-1:0]   w_cnt;
    logic [M-1:0]    w_y;
    logic            w_busy;
    logic            w_done;
    logic [1:0]      w_own;
    logic            w_wrap;

    assign w_own  = (r_state == S_SCAN) ? MD_SCAN : MD_SWEEP;
    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.en) begin
            r_state <= w_state;
            r_cur   <= w_cur;
            r_cnt   <= w_cnt;
            r_y     <= w_y;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Mode change beats restart, restart beats advance.
    always_comb begin
        w_state = r_state;
        w_cur   = r_cur;
        w_cnt   = r_cnt;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.mode == MD_DIRECT) begin
                    w_state = S_DIRECT;
                    w_cur   = bus.a;
                end else if (bus.start && bus.mode == MD_SCAN) begin
                    w_state = S_SCAN;
                    w_cur   = bus.a;
                    w_cnt   = '0;
                end else if (bus.start && bus.mode == MD_SWEEP) begin
                    w_state = S_SWEEP;
                    w_cur   = bus.a;
                    w_cnt   = '0;
                end
            end
            S_DIRECT: begin
                if (bus.mode == MD_DIRECT) begin
                    w_cur = bus.a;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SCAN, S_SWEEP: begin
                if (bus.mode != w_own) begin
                    w_cnt = '0;
                    if (bus.mode == MD_DIRECT) begin
                        w_state = S_DIRECT;
                        w_cur   = bus.a;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else if (bus.start) begin
                    w_cur = bus.a;
                    w_cnt = '0;
                end else if (!w_wrap) begin
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_cnt = '0;
                    if (r_state == S_SWEEP && r_cur == CMAX) begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_cur = r_cur + 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs are decoded from the next state, then registered.
    always_comb begin
        w_y = '0;
        if (w_state != S_IDLE) begin
            w_y[w_cur] = 1'b1;
        end
        w_busy = (w_state == S_SCAN) || (w_state == S_SWEEP);
    end

    assign bus.y    = r_y;
    assign bus.cur  = r_cur;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: one shared stimulus
// drives five parameterisations, each checked in its own sequence.
module tb_decoder_scan;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic       start;
    logic [1:0] mode;
    logic [4:0] a;

    int nvec;
    int nfail;

    decoder_scan_if #(.N(3)) b0 ();
    decoder_scan_if #(.N(3)) b1 ();
    decoder_scan_if #(.N(2)) b2 ();
    decoder_scan_if #(.N(1)) b3 ();
    decoder_scan_if #(.N(5)) b4 ();

    assign b0.en = en; assign b0.mode = mode;
    assign b0.start = start; assign b0.a = a[2:0];
    assign b1.en = en; assign b1.mode = mode;
    assign b1.start = start; assign b1.a = a[2:0];
    assign b2.en = en; assign b2.mode = mode;
    assign b2.start = start; assign b2.a = a[1:0];
    assign b3.en = en; assign b3.mode = mode;
    assign b3.start = start; assign b3.a = a[0:0];
    assign b4.en = en; assign b4.mode = mode;
    assign b4.start = start; assign b4.a = a;

    decoder_scan #(.N(3), .DWELL(2)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    decoder_scan #(.N(3), .DWELL(3)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    decoder_scan #(.N(2), .DWELL(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    decoder_scan #(.N(1), .DWELL(1)) d3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    decoder_scan #(.N(5), .DWELL(7)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       start;
        logic [2:0] a;
        logic [7:0] y;
        logic       busy;
    } dvec_t;

    dvec_t tbl[14];
    logic [7:0] scan_exp[8];
    logic [7:0] swp_exp[9];
    logic [3:0] gate_exp[6];
    int busy_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        start = 1'b0;
        mode  = 2'b11;
        tick();
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        tbl[0]  = '{2'd0, 1'b0, 3'd0, 8'h01, 1'b0};
        tbl[1]  = '{2'd0, 1'b0, 3'd1, 8'h02, 1'b0};
        tbl[2]  = '{2'd0, 1'b0, 3'd2, 8'h04, 1'b0};
        tbl[3]  = '{2'd0, 1'b0, 3'd3, 8'h08, 1'b0};
        tbl[4]  = '{2'd0, 1'b0, 3'd4, 8'h10, 1'b0};
        tbl[5]  = '{2'd0, 1'b0, 3'd5, 8'h20, 1'b0};
        tbl[6]  = '{2'd0, 1'b0, 3'd6, 8'h40, 1'b0};
        tbl[7]  = '{2'd0, 1'b0, 3'd7, 8'h80, 1'b0};
        tbl[8]  = '{2'd0, 1'b1, 3'd4, 8'h10, 1'b0};
        tbl[9]  = '{2'd3, 1'b0, 3'd5, 8'h00, 1'b0};
        tbl[10] = '{2'd1, 1'b0, 3'd3, 8'h00, 1'b0};
        tbl[11] = '{2'd2, 1'b0, 3'd3, 8'h00, 1'b0};
        tbl[12] = '{2'd0, 1'b0, 3'd6, 8'h40, 1'b0};
        tbl[13] = '{2'd3, 1'b1, 3'd1, 8'h00, 1'b0};
        scan_exp = '{8'h40, 8'h40, 8'h80, 8'h80,
                     8'h01, 8'h01, 8'h02, 8'h02};
        swp_exp  = '{8'h20, 8'h20, 8'h20, 8'h40, 8'h40,
                     8'h40, 8'h80, 8'h80, 8'h80};
        gate_exp = '{4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1};

        rst_n = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        mode  = 2'b11;
        a     = '0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_y",    32'(b0.y), 32'h0);
        chk("rst_cur",  32'(b0.cur), 32'h0);
        chk("rst_busy", 32'(b0.busy), 32'h0);
        chk("rst_done", 32'(b0.done), 32'h0);
        tick();
        #4 rst_n = 1'b1;
        tick();

        // DIRECT decode and IDLE transitions
        foreach (tbl[i]) begin
            mode  = tbl[i].mode;
            start = tbl[i].start;
            a     = 5'(tbl[i].a);
            tick();
            chk($sformatf("dir_y[%0d]", i), 32'(b0.y), 32'(tbl[i].y));
            chk($sformatf("dir_busy[%0d]", i), 32'(b0.busy),
                32'(tbl[i].busy));
            if (tbl[i].y != 8'h00)
                chk($sformatf("dir_cur[%0d]", i), 32'(b0.cur),
                    32'(tbl[i].a));
        end

        // asynchronous reset mid-run
        mode  = 2'b00;
        start = 1'b0;
        a     = 5'd5;
        tick();
        chk("pre_rst_y", 32'(b0.y), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_y",   32'(b0.y), 32'h0);
        chk("arst_cur", 32'(b0.cur), 32'h0);
        chk("arst_done", 32'(b0.done), 32'h0);
        #1 rst_n = 1'b1;
        go_idle();

        // SCAN wrap on d0 (N=3, DWELL=2)
        mode  = 2'b01;
        start = 1'b1;
        a     = 5'd6;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("scan_y[%0d]", i), 32'(b0.y), 32'(scan_exp[i]));
            chk($sformatf("scan_busy[%0d]", i), 32'(b0.busy), 32'h1);
        end
        mode = 2'b11;
        tick();
        chk("scan_off_y", 32'(b0.y), 32'h0);
        chk("scan_off_busy", 32'(b0.busy), 32'h0);
        go_idle();

        // SWEEP on d1 (N=3, DWELL=3) with done held under en=0
        mode     = 2'b10;
        start    = 1'b1;
        a        = 5'd5;
        busy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("swp_y[%0d]", i), 32'(b1.y), 32'(swp_exp[i]));
            chk($sformatf("swp_done[%0d]", i), 32'(b1.done), 32'h0);
            if (b1.busy) busy_cnt++;
        end
        chk("swp_busy_cycles", 32'(busy_cnt), 32'd9);
        tick();
        chk("swp_end_y", 32'(b1.y), 32'h0);
        chk("swp_end_busy", 32'(b1.busy), 32'h0);
        chk("swp_end_done", 32'(b1.done), 32'h1);
        en = 1'b0;
        tick();
        tick();
        chk("swp_done_hold", 32'(b1.done), 32'h1);
        en = 1'b1;
        tick();
        chk("swp_done_clr", 32'(b1.done), 32'h0);
        go_idle();

        // en gating mid-slot on d2 (N=2, DWELL=2)
        mode  = 2'b01;
        start = 1'b1;
        a     = 5'd1;
        tick();
        start = 1'b0;
        chk("gate_y0", 32'(b2.y), 32'h2);
        tick();
        chk("gate_y1", 32'(b2.y), 32'h2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("gate_frz_y[%0d]", i), 32'(b2.y), 32'h2);
            chk($sformatf("gate_frz_cur[%0d]", i), 32'(b2.cur), 32'h1);
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("gate_y[%0d]", i), 32'(b2.y), 32'(gate_exp[i]));
        end
        go_idle();

        // SWEEP restart mid-run on d0 (N=3, DWELL=2)
        mode  = 2'b10;
        start = 1'b1;
        a     = 5'd2;
        tick();
        start = 1'b0;
        chk("rs_y0", 32'(b0.y), 32'h04);
        tick();
        chk("rs_y1", 32'(b0.y), 32'h04);
        start = 1'b1;
        a     = 5'd6;
        tick();
        start = 1'b0;
        chk("rs_y2", 32'(b0.y), 32'h40);
        tick();
        chk("rs_y3", 32'(b0.y), 32'h40);
        tick();
        chk("rs_y4", 32'(b0.y), 32'h80);
        chk("rs_done4", 32'(b0.done), 32'h0);
        tick();
        chk("rs_y5", 32'(b0.y), 32'h80);
        chk("rs_done5", 32'(b0.done), 32'h0);
        tick();
        chk("rs_end_y", 32'(b0.y), 32'h0);
        chk("rs_end_done", 32'(b0.done), 32'h1);
        go_idle();

        // restart on the completion edge suppresses done
        mode  = 2'b10;
        start = 1'b1;
        a     = 5'd7;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rc_y", 32'(b0.y), 32'h80);
        chk("rc_done", 32'(b0.done), 32'h0);
        tick();
        chk("rc_y1", 32'(b0.y), 32'h80);
        tick();
        chk("rc_end_done", 32'(b0.done), 32'h1);
        go_idle();

        // abort SWEEP into DIRECT
        mode  = 2'b10;
        start = 1'b1;
        a     = 5'd0;
        tick();
        start = 1'b0;
        chk("ab_y0", 32'(b0.y), 32'h01);
        tick();
        mode = 2'b00;
        a    = 5'd3;
        tick();
        chk("ab_y", 32'(b0.y), 32'h08);
        chk("ab_busy", 32'(b0.busy), 32'h0);
        chk("ab_done", 32'(b0.done), 32'h0);
        a = 5'd5;
        tick();
        chk("ab_y2", 32'(b0.y), 32'h20);
        chk("ab_done2", 32'(b0.done), 32'h0);
        go_idle();

        // N=1, DWELL=1 full sweep
        mode  = 2'b10;
        start = 1'b1;
        a     = 5'd0;
        tick();
        start = 1'b0;
        chk("n1_y0", 32'(b3.y), 32'h1);
        tick();
        chk("n1_y1", 32'(b3.y), 32'h2);
        chk("n1_done1", 32'(b3.done), 32'h0);
        tick();
        chk("n1_end_y", 32'(b3.y), 32'h0);
        chk("n1_end_done", 32'(b3.done), 32'h1);
        go_idle();

        // N=5, DWELL=7 full sweep
        mode  = 2'b10;
        start = 1'b1;
        a     = 5'd0;
        for (int i = 0; i < 224; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("n5_y[%0d]", i), b4.y, 32'h1 << (i / 7));
        end
        tick();
        chk("n5_end_y", b4.y, 32'h0);
        chk("n5_end_done", 32'(b4.done), 32'h1);
        tick();
        chk("n5_done_clr", 32'(b4.done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
